mac_stream16: RTL and testbench

Operand sequencer and multiplier that produces the 20-bit din stream consumed by the 16-beat bias accumulator. It holds 16 signed 8-bit activation/weight pairs loaded through a register-write port. On start it streams 16 signed products, one per accepted beat, with first/last framing so the accumulator aligns bias injection and sum capture. It sits between the layer controller (or SRAM reader) and the accumulator.

---
 rtl/mac_stream16.sv | 135 +++++++++++++
 tb/tb_mac_stream16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream16.sv
// rtl/mac_stream16.sv - operand store and signed product streamer feeding the 16-beat accumulator
// Holds N_BEATS x/w pairs and emits one sign-extended x*w per accepted beat with first/last framing.
module mac_stream16 #(
    parameter int N_BEATS = 16,
    parameter int DW      = 8,
    parameter int OW      = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(N_BEATS)-1:0] wr_addr,
    input  logic [DW-1:0]              wr_x,
    input  logic [DW-1:0]              wr_w,
    input  logic                       start,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OW-1:0]              out_data,
    output logic                       out_first,
    output logic                       out_last,
    output logic                       done
);
    localparam int CW = $clog2(N_BEATS);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [DW-1:0]   r_x [N_BEATS];
    logic [DW-1:0]   r_w [N_BEATS];
    logic            r_busy, r_valid, r_first, r_last, r_done;
    logic            w_busy, w_valid, w_first, w_last, w_done;
    logic [OW-1:0]   r_data, w_data;
    logic [OW-1:0]   w_prod;
    logic [CW-1:0]   w_idx;
    logic            w_bypass;
    logic            w_accept;
    logic signed [2*DW-1:0] w_prod_raw;

    assign w_accept  = r_valid & out_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Beat 0 must see a slot-0 write landing on the same edge as start.
    assign w_bypass = (r_state == IDLE) && wr_en && (wr_addr == '0);
    assign w_idx    = (r_state == RUN) ? w_cnt_inc : '0;

    assign w_prod_raw = $signed(w_bypass ? wr_x : r_x[w_idx]) *
                        $signed(w_bypass ? wr_w : r_w[w_idx]);
    assign w_prod     = {{(OW-2*DW){w_prod_raw[2*DW-1]}}, w_prod_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < N_BEATS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy;
            r_valid <= w_valid;
            r_first <= w_first;
            r_last  <= w_last;
            r_done  <= w_done;
            r_data  <= w_data;
            if (wr_en && (r_state == IDLE)) begin
                r_x[wr_addr] <= wr_x;
                r_w[wr_addr] <= wr_w;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = r_busy;
        w_valid     = r_valid;
        w_first     = r_first;
        w_last      = r_last;
        w_data      = r_data;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_busy      = 1'b1;
                    w_valid     = 1'b1;
                    w_first     = 1'b1;
                    w_last      = 1'b0;
                    w_data      = w_prod;
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_first = 1'b0;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt = DONE;
                        w_busy      = 1'b0;
                        w_valid     = 1'b0;
                        w_last      = 1'b0;
                        w_done      = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        w_data    = w_prod;
                        w_last    = (w_cnt_inc == LAST_IDX);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_first = r_first;
    assign out_last  = r_last;
    assign out_data  = r_data;
    assign done      = r_done;

endmodule

// File: tb/tb_mac_stream16.sv
// tb/tb_mac_stream16.sv - randomized self-checking bench for mac_stream16
// Reference model: plain integer arrays of operands, expected beat k = x[k]*w[k] truncated to 20 bits.
module tb_mac_stream16;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_x, wr_w;
    logic        start;
    logic        busy, out_valid, out_ready, out_first, out_last, done;
    logic [19:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int mx [N];
    int mw [N];

    mac_stream16 dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_w(wr_w),
        .start(start), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] exp_prod(input int k);
        int p;
        p = mx[k] * mw[k];
        return p[19:0];
    endfunction

    // Every task is entered and left one time unit after a rising edge.
    task automatic wr(input int k, input int x, input int w);
        wr_en = 1'b1; wr_addr = 4'(k); wr_x = 8'(x); wr_w = 8'(w);
        @(posedge clk); #1;
        wr_en = 1'b0;
        mx[k] = x; mw[k] = w;
    endtask

    task automatic load_random();
        @(posedge clk); #1;
        for (int k = 0; k < N; k++)
            wr(k, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic do_start(input bit with_wr0, input int x0, input int w0);
        start = 1'b1;
        if (with_wr0) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_x = 8'(x0); wr_w = 8'(w0);
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        if (with_wr0) begin
            mx[0] = x0; mw[0] = w0;
        end
    endtask

    // mode 0: always ready; 1: 5-cycle stall at beat 3 then toggling; 2: random ready plus
    // a mid-frame write to slot 10 and a spurious start. abort_at >= 0 resets at that beat.
    task automatic run_frame(input int mode, input int abort_at);
        int beat = 0, cyc = 0, stall = 0;
        bit inj = 1'b0, tog = 1'b1, prev_hold = 1'b0, rdy;
        logic [19:0] prev_d = '0;
        while (beat < N && cyc < 400) begin
            if (mode == 1 && beat == 3 && stall < 5) begin
                rdy = 1'b0; stall++;
            end else if (mode == 1 && beat >= 3) begin
                rdy = tog; tog = ~tog;
            end else if (mode == 2) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            if (mode == 2 && beat == 5 && !inj) begin
                wr_en = 1'b1; wr_addr = 4'd10; wr_x = 8'd5; wr_w = 8'd5; start = 1'b1; inj = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            #4;
            if (abort_at == beat) begin
                rst = 1'b1;
                #1;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_first", out_first, 0);
                chk("abort_last", out_last, 0);
                chk("abort_data", out_data, 0);
                chk("abort_done", done, 0);
                @(posedge clk); #1;
                chk("abort_done_after", done, 0);
                rst = 1'b0; out_ready = 1'b0;
                for (int k = 0; k < N; k++) begin
                    mx[k] = 0; mw[k] = 0;
                end
                return;
            end
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("done_mid", done, 0);
            if (prev_hold) chk("stall_hold", out_data, prev_d);
            chk($sformatf("data_b%0d", beat), out_data, exp_prod(beat));
            chk("first", out_first, (beat == 0));
            chk("last", out_last, (beat == N - 1));
            prev_hold = !rdy;
            prev_d = out_data;
            if (rdy) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0;
        if (beat < N) begin
            chk("frame_timeout", beat, N);
        end else begin
            chk("done_pulse", done, 1);
            chk("busy_end", busy, 0);
            chk("valid_end", out_valid, 0);
            chk("last_end", out_last, 0);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_w = '0; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            mx[k] = 0; mw[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // ramp 0..15
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) wr(k, k, 1);
        do_start(1'b0, 0, 0);
        run_frame(0, -1);
        @(posedge clk); #1;
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);

        // sign extremes; slot 0 written in the same cycle as start
        load_random();
        wr(1, 127, -128);
        do_start(1'b1, -128, -128);
        run_frame(0, -1);

        // backpressure
        load_random();
        do_start(1'b0, 0, 0);
        run_frame(1, -1);

        // write and start while busy are ignored
        load_random();
        do_start(1'b0, 0, 0);
        run_frame(2, -1);
        @(posedge clk); #1;
        chk("no_restart_valid", out_valid, 0);
        chk("no_restart_done", done, 0);

        // reset at beat 7, then slots read back as zero, then reload
        load_random();
        do_start(1'b0, 0, 0);
        run_frame(0, 7);
        @(posedge clk); #1;
        chk("post_abort_done", done, 0);
        do_start(1'b0, 0, 0);
        run_frame(0, -1);
        load_random();
        do_start(1'b0, 0, 0);
        run_frame(0, -1);

        // back-to-back: start in DONE ignored, start in next IDLE cycle honoured
        start = 1'b1;
        @(posedge clk); #1;
        chk("done_start_ignored", out_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        run_frame(2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=finished", $time);
        $fatal(1, "timeout");
    end
endmodule
